// File: rtl/mem_boot_loader.sv
// Boot sequencer: holds the core in reset while a byte stream is packed into
// little-endian words and written from address 0, then hands the memory port to the datapath.
module mem_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_COUNT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] load_addr_reg, load_addr_next;
    logic [1:0]            byte_idx_reg, byte_idx_next;
    logic [DATA_WIDTH-1:0] asm_reg, asm_next;
    logic [ADDR_WIDTH:0]   word_cnt_reg, word_cnt_next;
    logic                  cpu_hold_reg, load_done_reg;
    logic                  restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            load_addr_reg <= '0;
            byte_idx_reg  <= '0;
            asm_reg       <= '0;
            word_cnt_reg  <= '0;
            cpu_hold_reg  <= 1'b1;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            load_addr_reg <= load_addr_next;
            byte_idx_reg  <= byte_idx_next;
            asm_reg       <= asm_next;
            word_cnt_reg  <= word_cnt_next;
            cpu_hold_reg  <= (state_next != RUN);
            load_done_reg <= (state_next == RUN);
        end
    end

    // A write in flight always completes, so load_start is ignored in WRITE.
    assign restart = load_start && (state_reg != WRITE);

    always_comb begin
        state_next     = state_reg;
        load_addr_next = load_addr_reg;
        byte_idx_next  = byte_idx_reg;
        asm_next       = asm_reg;
        word_cnt_next  = word_cnt_reg;
        case (state_reg)
            IDLE: ;
            COLLECT: begin
                if (byte_valid) begin
                    asm_next[{byte_idx_reg, 3'b000} +: 8] = byte_data;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                word_cnt_next = word_cnt_reg + CNT_ONE;
                if (load_addr_reg == LAST_ADDR) begin
                    state_next = RUN;
                end else begin
                    load_addr_next = load_addr_reg + ADDR_ONE;
                    byte_idx_next  = 2'd0;
                    state_next     = COLLECT;
                end
            end
            RUN: ;
            default: state_next = IDLE;
        endcase
        // Restart overrides any byte accepted in the same cycle.
        if (restart) begin
            state_next     = COLLECT;
            load_addr_next = '0;
            byte_idx_next  = 2'd0;
            word_cnt_next  = '0;
            asm_next       = '0;
        end
    end

    always_comb begin
        if (state_reg == RUN) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else begin
            mem_addr  = load_addr_reg;
            mem_wdata = asm_reg;
            mem_we    = (state_reg == WRITE);
        end
    end

    assign byte_ready = (state_reg == COLLECT);
    assign cpu_hold   = cpu_hold_reg;
    assign load_done  = load_done_reg;
    assign word_cnt   = word_cnt_reg;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench: one loader with WORD_COUNT=3 and one with WORD_COUNT=1 share the stimulus.
module tb_mem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [7:0]  cpu_addr = 8'h00;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_we = 1'b0;

    logic        a_byte_ready, a_mem_we, a_cpu_hold, a_load_done;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [8:0]  a_word_cnt;
    logic        b_byte_ready, b_mem_we, b_cpu_hold, b_load_done;
    logic [7:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [8:0]  b_word_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_words [3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};

    mem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WORD_COUNT(3)) dut3 (
        .clk(clk), .reset(reset), .load_start(load_start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(a_byte_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .cpu_hold(a_cpu_hold), .load_done(a_load_done), .word_cnt(a_word_cnt)
    );

    mem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WORD_COUNT(1)) dut1 (
        .clk(clk), .reset(reset), .load_start(load_start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(b_byte_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .cpu_hold(b_cpu_hold), .load_done(b_load_done), .word_cnt(b_word_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hold"},  32'(a_cpu_hold), 32'h1);
        chk({tag, "_done"},  32'(a_load_done), 32'h0);
        chk({tag, "_ready"}, 32'(a_byte_ready), 32'h0);
        chk({tag, "_we"},    32'(a_mem_we), 32'h0);
        chk({tag, "_addr"},  32'(a_mem_addr), 32'h0);
        chk({tag, "_wdata"}, a_mem_wdata, 32'h0);
        chk({tag, "_cnt"},   32'(a_word_cnt), 32'h0);
    endtask

    initial begin
        // Reset values
        #8;
        chk_reset("rst");
        chk("rst_b_hold", 32'(b_cpu_hold), 32'h1);
        #4 reset = 1'b0;

        // Single word 0x12345678: dut1 finishes, dut3 continues
        tick; load_start = 1'b1; settle;
        chk("idle_ready", 32'(a_byte_ready), 32'h0);
        tick; load_start = 1'b0; byte_valid = 1'b1; byte_data = 8'h78; settle;
        chk("col_ready", 32'(a_byte_ready), 32'h1);
        tick; byte_data = 8'h56;
        tick; byte_data = 8'h34;
        tick; byte_data = 8'h12;
        tick; byte_valid = 1'b0; settle;
        chk("w1_b_we", 32'(b_mem_we), 32'h1);
        chk("w1_b_addr", 32'(b_mem_addr), 32'h0);
        chk("w1_b_wdata", b_mem_wdata, 32'h12345678);
        chk("w1_a_wdata", a_mem_wdata, 32'h12345678);
        chk("w1_ready", 32'(a_byte_ready), 32'h0);
        tick; settle;
        chk("run1_b_hold", 32'(b_cpu_hold), 32'h0);
        chk("run1_b_done", 32'(b_load_done), 32'h1);
        chk("run1_b_cnt", 32'(b_word_cnt), 32'h1);
        chk("run1_a_hold", 32'(a_cpu_hold), 32'h1);
        chk("run1_a_addr", 32'(a_mem_addr), 32'h1);
        chk("run1_a_cnt", 32'(a_word_cnt), 32'h1);

        // Restart both; 12 continuous bytes into the 3-word loader
        load_start = 1'b1;
        tick; load_start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            byte_valid = 1'b1;
            if (c % 5 == 0) begin
                byte_data = 8'hFF;
                settle;
                chk($sformatf("t3_we_c%0d", c), 32'(a_mem_we), 32'h1);
                chk($sformatf("t3_addr_c%0d", c), 32'(a_mem_addr), 32'(c / 5 - 1));
                chk($sformatf("t3_wdata_c%0d", c), a_mem_wdata, exp_words[c / 5 - 1]);
            end else begin
                byte_data = 8'((c / 5) * 4 + (c % 5) - 1);
                settle;
                chk($sformatf("t3_nowe_c%0d", c), 32'(a_mem_we), 32'h0);
                if (c == 1) begin
                    chk("restart_b_hold", 32'(b_cpu_hold), 32'h1);
                    chk("restart_a_cnt", 32'(a_word_cnt), 32'h0);
                end
            end
            tick;
        end
        byte_valid = 1'b0; settle;
        chk("t3_run_hold", 32'(a_cpu_hold), 32'h0);
        chk("t3_run_done", 32'(a_load_done), 32'h1);
        chk("t3_run_cnt", 32'(a_word_cnt), 32'h3);

        // Passthrough in RUN, blocked in COLLECT
        cpu_addr = 8'h2A; cpu_wdata = 32'hDEADBEEF; cpu_we = 1'b1; settle;
        chk("pass_addr", 32'(a_mem_addr), 32'h2A);
        chk("pass_wdata", a_mem_wdata, 32'hDEADBEEF);
        chk("pass_we", 32'(a_mem_we), 32'h1);
        chk("run_ready", 32'(a_byte_ready), 32'h0);
        load_start = 1'b1;
        tick; load_start = 1'b0; settle;
        chk("blk_we", 32'(a_mem_we), 32'h0);
        chk("blk_addr", 32'(a_mem_addr), 32'h0);
        chk("blk_hold", 32'(a_cpu_hold), 32'h1);
        chk("blk_cnt", 32'(a_word_cnt), 32'h0);
        cpu_we = 1'b0;

        // byte_valid toggling: 8 collect cycles then WRITE
        for (int c = 1; c <= 8; c++) begin
            byte_valid = (c % 2 == 0);
            byte_data = (c % 2 == 0) ? 8'(8'hA0 + c / 2 - 1) : 8'hEE;
            if (c == 8) begin
                settle;
                chk("tog_nowe", 32'(a_mem_we), 32'h0);
            end
            tick;
        end
        byte_valid = 1'b0; settle;
        chk("tog_we", 32'(a_mem_we), 32'h1);
        chk("tog_addr", 32'(a_mem_addr), 32'h0);
        chk("tog_wdata", a_mem_wdata, 32'hA3A2A1A0);
        tick; settle;
        chk("tog_cnt", 32'(a_word_cnt), 32'h1);
        chk("tog_next_addr", 32'(a_mem_addr), 32'h1);

        // load_start with the third byte handshake
        byte_valid = 1'b1; byte_data = 8'hB0;
        tick; byte_data = 8'hB1;
        tick; byte_data = 8'hB2; load_start = 1'b1;
        tick; load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            byte_data = 8'(8'hC0 + i);
            settle;
            if (i == 0) chk("ls_addr", 32'(a_mem_addr), 32'h0);
            chk($sformatf("ls_cnt_%0d", i), 32'(a_word_cnt), 32'h0);
            tick;
        end
        byte_valid = 1'b0; settle;
        chk("ls_we", 32'(a_mem_we), 32'h1);
        chk("ls_addr_w", 32'(a_mem_addr), 32'h0);
        chk("ls_wdata", a_mem_wdata, 32'hC3C2C1C0);
        tick; settle;
        chk("ls_cnt_after", 32'(a_word_cnt), 32'h1);

        // Asynchronous reset after two bytes of a word
        byte_valid = 1'b1; byte_data = 8'hD0;
        tick; byte_data = 8'hD1;
        tick; byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset("arst");
        #1 reset = 1'b0;

        // Fresh boot; load_start during WRITE is ignored
        tick; load_start = 1'b1;
        tick; load_start = 1'b0; byte_valid = 1'b1; byte_data = 8'h11;
        tick; byte_data = 8'h22;
        tick; byte_data = 8'h33;
        tick; byte_data = 8'h44;
        tick; byte_valid = 1'b0; load_start = 1'b1; settle;
        chk("fb_we", 32'(a_mem_we), 32'h1);
        chk("fb_addr", 32'(a_mem_addr), 32'h0);
        chk("fb_wdata", a_mem_wdata, 32'h44332211);
        tick; load_start = 1'b0; settle;
        chk("fb_b_done", 32'(b_load_done), 32'h1);
        chk("fb_b_hold", 32'(b_cpu_hold), 32'h0);
        chk("fb_a_cnt", 32'(a_word_cnt), 32'h1);
        chk("fb_a_addr", 32'(a_mem_addr), 32'h1);
        chk("fb_a_ready", 32'(a_byte_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
